// File: rtl/funct_generator_burst_ctrl.sv
// Burst scheduler for the function generator: configures it, runs it for a
// requested number of samples, pauses on downstream backpressure and reports status.
module funct_generator_burst_ctrl #(
  parameter int INT_BITS    = 8,
  parameter int CNT_W       = 16,
  parameter int CONF_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [CNT_W-1:0]           burst_len_i,
  input  logic [1:0]                 sel_cfg_i,
  input  logic signed [INT_BITS-1:0] amp_cfg_i,
  input  logic                       gen_wr_en_i,
  input  logic                       fifo_full_i,
  output logic                       gen_en_low_o,
  output logic                       gen_enh_conf_o,
  output logic [1:0]                 gen_sel_o,
  output logic signed [INT_BITS-1:0] gen_amp_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_W-1:0]           samples_o,
  output logic                       overflow_o
);

  localparam int CONF_W = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONF_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONF, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t                     state_reg, state_next;
  logic [CONF_W-1:0]          conf_cnt_reg, conf_cnt_next;
  logic [CNT_W-1:0]           len_reg, len_next;
  logic [CNT_W-1:0]           samples_reg, samples_next;
  logic                       ovf_reg, ovf_next;
  logic [1:0]                 sel_reg, sel_next;
  logic signed [INT_BITS-1:0] amp_reg, amp_next;
  logic                       en_low_reg, en_low_next;
  logic                       conf_reg, conf_next;
  logic                       busy_reg, busy_next;
  logic                       done_reg, done_next;

  logic [CNT_W-1:0] samples_inc;
  logic             last_sample;
  logic             ovf_clear;

  assign samples_inc = samples_reg + CNT_W'(1);
  // Completion only counts on a real sample strobe.
  assign last_sample = gen_wr_en_i && (samples_inc == len_reg);

  always_comb begin
    state_next    = state_reg;
    conf_cnt_next = conf_cnt_reg;
    len_next      = len_reg;
    samples_next  = samples_reg;
    sel_next      = sel_reg;
    amp_next      = amp_reg;
    ovf_clear     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          if (burst_len_i != '0) begin
            len_next      = burst_len_i;
            sel_next      = sel_cfg_i;
            amp_next      = amp_cfg_i;
            samples_next  = '0;
            ovf_clear     = 1'b1;
            conf_cnt_next = '0;
            state_next    = S_CONF;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_CONF: begin
        if (abort_i) begin
          state_next = S_IDLE;
        end else if (conf_cnt_reg == CONF_LAST) begin
          state_next = S_RUN;
        end else begin
          conf_cnt_next = conf_cnt_reg + CONF_W'(1);
        end
      end
      S_RUN, S_PAUSE: begin
        if (abort_i) begin
          state_next = S_IDLE;
        end else begin
          if (gen_wr_en_i) samples_next = samples_inc;
          // Completion beats backpressure; otherwise pause tracks fifo_full_i.
          if (last_sample) state_next = S_DONE;
          else if (fifo_full_i) state_next = S_PAUSE;
          else state_next = S_RUN;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    ovf_next = (ovf_clear ? 1'b0 : ovf_reg) | (gen_wr_en_i & fifo_full_i);

    // Outputs are registered views of the state being entered.
    en_low_next = (state_next != S_RUN);
    conf_next   = (state_next == S_CONF);
    busy_next   = (state_next != S_IDLE);
    done_next   = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      conf_cnt_reg <= '0;
      len_reg      <= '0;
      samples_reg  <= '0;
      ovf_reg      <= 1'b0;
      sel_reg      <= '0;
      amp_reg      <= '0;
      en_low_reg   <= 1'b1;
      conf_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      conf_cnt_reg <= conf_cnt_next;
      len_reg      <= len_next;
      samples_reg  <= samples_next;
      ovf_reg      <= ovf_next;
      sel_reg      <= sel_next;
      amp_reg      <= amp_next;
      en_low_reg   <= en_low_next;
      conf_reg     <= conf_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign gen_en_low_o   = en_low_reg;
  assign gen_enh_conf_o = conf_reg;
  assign gen_sel_o      = sel_reg;
  assign gen_amp_o      = amp_reg;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign samples_o      = samples_reg;
  assign overflow_o     = ovf_reg;

endmodule
